// File: rtl/aoi_exp_3.sv
// Registered five-group AND-OR-INVERT expander cell with chaining outputs.
// Define AOI_EXP_3_XIN_EN to let the XIN expander input join the OR sum.
module aoi_exp_3 #(
    parameter logic RESET_Y = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic       H,
    input  logic       I,
    input  logic       J,
    input  logic       XIN,
    output logic [4:0] T,
    output logic       XOUT,
    output logic       YC,
    output logic       Y
);

    logic xin_g;
    logic y_d, y_q;

`ifdef AOI_EXP_3_XIN_EN
    assign xin_g = XIN;
`else
    // Port kept for pin compatibility; the expander path is tied off.
    logic unused_xin;
    assign unused_xin = XIN;
    assign xin_g      = 1'b0;
`endif

    always_comb begin
        T[0] = A & B;
        T[1] = C & D;
        T[2] = E & F;
        T[3] = G & H;
        T[4] = I & J;
        XOUT = (|T) | xin_g;
        YC   = ~XOUT;
    end

    always_comb begin
        y_d = y_q;
        if (RST) begin
            y_d = RESET_Y;
        end else if (EN) begin
            y_d = YC;
        end
    end

    always_ff @(posedge CLK) begin
        y_q <= y_d;
    end

    assign Y = y_q;

endmodule

// File: tb/tb_aoi_exp_3.sv
// Self-checking bench for aoi_exp_3: expected Y values are queued at drive time
// and popped one edge later; combinational outputs are checked immediately.
module tb_aoi_exp_3;

    localparam logic RESET_Y_TB = 1'b1;

    logic       clk;
    logic       rst_s;
    logic       en_s;
    logic [9:0] din;
    logic       xin;
    logic [4:0] t_o;
    logic       xout_o;
    logic       yc_o;
    logic       y_o;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic y_model;

    aoi_exp_3 #(
        .RESET_Y(RESET_Y_TB)
    ) dut (
        .CLK (clk),
        .RST (rst_s),
        .EN  (en_s),
        .A   (din[0]),
        .B   (din[1]),
        .C   (din[2]),
        .D   (din[3]),
        .E   (din[4]),
        .F   (din[5]),
        .G   (din[6]),
        .H   (din[7]),
        .I   (din[8]),
        .J   (din[9]),
        .XIN (xin),
        .T   (t_o),
        .XOUT(xout_o),
        .YC  (yc_o),
        .Y   (y_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_t(input logic [9:0] d);
        logic [4:0] t;
        for (int k = 0; k < 5; k++) t[k] = d[2*k] & d[2*k+1];
        return t;
    endfunction

    function automatic logic model_xg(input logic x);
`ifdef AOI_EXP_3_XIN_EN
        return x;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of stimulus and queue the Y expected after the next edge.
    task automatic apply(input logic [9:0] d, input logic x, input logic en,
                         input logic rst);
        din   = d;
        xin   = x;
        en_s  = en;
        rst_s = rst;
        if (rst) y_model = RESET_Y_TB;
        else if (en) y_model = ~((|model_t(d)) | model_xg(x));
        exp_q.push_back(y_model);
    endtask

    task automatic test_reset();
        logic e;
        for (int c = 0; c < 2; c++) begin
            apply(10'd0, 1'b0, 1'b0, 1'b1);
            #1;
            checks++;
            if (t_o !== 5'b00000) begin
                errors++; $display("FAIL reset_t: got %b want 00000", t_o);
            end
            checks++;
            if (xout_o !== 1'b0 || yc_o !== 1'b1) begin
                errors++; $display("FAIL reset_comb: xout=%b yc=%b want 0/1", xout_o, yc_o);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (y_o !== 1'b1 || e !== 1'b1) begin
                errors++; $display("FAIL reset_y: got %b want 1", y_o);
            end
        end
        apply(10'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (y_o !== 1'b1) begin
            errors++; $display("FAIL reset_release_y: got %b want 1", y_o);
        end
    endtask

    task automatic test_alternating();
        logic e;
        apply(10'b00_0101_0101, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (t_o !== 5'b00000 || yc_o !== 1'b1) begin
            errors++; $display("FAIL alt_comb: t=%b yc=%b want 00000/1", t_o, yc_o);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (y_o !== e || y_o !== 1'b1) begin
            errors++; $display("FAIL alt_y: got %b want 1", y_o);
        end
    endtask

    task automatic test_pairs();
        logic e;
        logic [9:0] d;
        logic [4:0] tw;
        for (int k = 0; k < 5; k++) begin
            d  = 10'd3 << (2 * k);
            tw = 5'd1 << k;
            apply(d, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (t_o !== tw || xout_o !== 1'b1 || yc_o !== 1'b0) begin
                errors++;
                $display("FAIL pair%0d_comb: t=%b xout=%b yc=%b want %b/1/0",
                         k, t_o, xout_o, yc_o, tw);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (y_o !== e || y_o !== 1'b0) begin
                errors++; $display("FAIL pair%0d_y: got %b want 0", k, y_o);
            end
        end
    endtask

    task automatic test_hold();
        logic e;
        apply(10'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (y_o !== 1'b1) begin
            errors++; $display("FAIL hold_pre_y: got %b want 1", y_o);
        end
        for (int c = 0; c < 3; c++) begin
            apply(10'b00_0000_0011, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (y_o !== e || y_o !== 1'b1) begin
                errors++; $display("FAIL hold_y%0d: got %b want 1", c, y_o);
            end
        end
        apply(10'b00_0000_0011, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (y_o !== 1'b0) begin
            errors++; $display("FAIL hold_en_y: got %b want 0", y_o);
        end
        apply(10'b00_0000_0011, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (y_o !== 1'b1) begin
            errors++; $display("FAIL rst_over_en_y: got %b want 1", y_o);
        end
    endtask

    task automatic test_xin();
        logic e;
        logic xo_w, yc_w;
`ifdef AOI_EXP_3_XIN_EN
        xo_w = 1'b1; yc_w = 1'b0;
`else
        xo_w = 1'b0; yc_w = 1'b1;
`endif
        apply(10'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (xout_o !== xo_w || yc_o !== yc_w) begin
            errors++;
            $display("FAIL xin_comb: xout=%b yc=%b want %b/%b", xout_o, yc_o, xo_w, yc_w);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (y_o !== yc_w) begin
            errors++; $display("FAIL xin_y: got %b want %b", y_o, yc_w);
        end
    endtask

    task automatic test_exhaustive();
        logic e;
        logic [9:0] d;
        logic g;
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            d = i[9:0];
            g = ~((d[0] & d[1]) | (d[2] & d[3]) | (d[4] & d[5]) | (d[6] & d[7]) |
                  (d[8] & d[9]));
            apply(d, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (yc_o !== g) begin
                errors++; $display("FAIL exh_yc[%0d]: got %b want %b", i, yc_o, g);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (y_o !== g || e !== g) begin
                errors++; $display("FAIL exh_y[%0d]: got %b want %b", i, y_o, g);
            end
        end
    endtask

    task automatic test_random();
        logic e;
        logic [9:0] d;
        logic x, en, rst;
        for (int i = 0; i < 300; i++) begin
            d   = 10'($urandom);
            x   = 1'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            apply(d, x, en, rst);
            #1;
            checks++;
            if (t_o !== model_t(d) || xout_o !== ((|model_t(d)) | model_xg(x)) ||
                yc_o !== ~((|model_t(d)) | model_xg(x))) begin
                errors++;
                $display("FAIL rnd_comb[%0d]: t=%b xout=%b yc=%b want t=%b", i, t_o, xout_o,
                         yc_o, model_t(d));
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (y_o !== e) begin
                errors++; $display("FAIL rnd_y[%0d]: got %b want %b", i, y_o, e);
            end
        end
    endtask

    initial begin
        din   = 10'd0;
        xin   = 1'b0;
        en_s  = 1'b0;
        rst_s = 1'b1;
        y_model = RESET_Y_TB;
        test_reset();
        test_alternating();
        test_pairs();
        test_hold();
        test_xin();
        test_exhaustive();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
